// File: rtl/video_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_timing_gen : pixel/line counters, blanking, VCLK, sync, frame parity
//                    and refresh DMA window; raster IRQ when VTG_RASTER_IRQ_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_WIDTH     = 9,
  parameter int V_WIDTH     = 9,
  parameter int H_START     = 128,
  parameter int H_END       = 511,
  parameter int V_START     = 248,
  parameter int V_END       = 511,
  parameter int H_VINC      = 175,
  parameter int VCLK_FIRST  = 175,
  parameter int VCLK_LAST   = 206,
  parameter int VACT_FIRST  = 271,
  parameter int VACT_LAST   = 494,
  parameter int VBH_FIRST   = 248,
  parameter int VBH_LAST    = 270,
  parameter int DMA_FIRST   = 479,
  parameter int DMA_LAST    = 494,
  parameter int PARITY_LINE = 495
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_MRST_n,
  input  logic               i_EMU_CLK6MPCEN_n,
  input  logic               i_HFLIP,
  input  logic               i_VFLIP,
  input  logic [V_WIDTH-1:0] i_IRQ_LINE,
  input  logic               i_IRQ_ACK,
  output logic [H_WIDTH-1:0] o_HCNT,
  output logic [V_WIDTH-1:0] o_VCNT,
  output logic [H_WIDTH-2:0] o_FLIP_H,
  output logic [V_WIDTH-2:0] o_FLIP_V,
  output logic               o_HBLANK_n,
  output logic               o_VBLANK_n,
  output logic               o_VBLANKH_n,
  output logic               o_REF_DMA_n,
  output logic               o_VCLK,
  output logic               o_FRAMEPARITY,
  output logic               o_VSYNC_n,
  output logic               o_CSYNC_n,
  output logic               o_LINE_IRQ_n
);

  localparam logic [H_WIDTH-1:0] C_H_START     = H_WIDTH'(H_START);
  localparam logic [H_WIDTH-1:0] C_H_END       = H_WIDTH'(H_END);
  localparam logic [H_WIDTH-1:0] C_H_VINC      = H_WIDTH'(H_VINC);
  localparam logic [H_WIDTH-1:0] C_VCLK_FIRST  = H_WIDTH'(VCLK_FIRST);
  localparam logic [H_WIDTH-1:0] C_VCLK_LAST   = H_WIDTH'(VCLK_LAST);
  localparam logic [V_WIDTH-1:0] C_V_START     = V_WIDTH'(V_START);
  localparam logic [V_WIDTH-1:0] C_V_END       = V_WIDTH'(V_END);
  localparam logic [V_WIDTH-1:0] C_VACT_FIRST  = V_WIDTH'(VACT_FIRST);
  localparam logic [V_WIDTH-1:0] C_VACT_LAST   = V_WIDTH'(VACT_LAST);
  localparam logic [V_WIDTH-1:0] C_VBH_FIRST   = V_WIDTH'(VBH_FIRST);
  localparam logic [V_WIDTH-1:0] C_VBH_LAST    = V_WIDTH'(VBH_LAST);
  localparam logic [V_WIDTH-1:0] C_DMA_FIRST   = V_WIDTH'(DMA_FIRST);
  localparam logic [V_WIDTH-1:0] C_DMA_LAST    = V_WIDTH'(DMA_LAST);
  localparam logic [V_WIDTH-1:0] C_PARITY_LINE = V_WIDTH'(PARITY_LINE);

  logic               tick;
  logic               h_wrap;
  logic               v_adv;
  logic [H_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [V_WIDTH-1:0] vcnt_q, vcnt_d;
  logic               vclk_q, vclk_d;
  logic               vblank_n_q, vblank_n_d;
  logic               vblankh_n_q, vblankh_n_d;
  logic               ref_dma_n_q, ref_dma_n_d;
  logic               parity_q, parity_d;

  assign tick   = ~i_EMU_CLK6MPCEN_n;
  assign h_wrap = (hcnt_q >= C_H_END);
  // The wrap tick never advances V, even if H_VINC were placed on H_END.
  assign v_adv  = tick && !h_wrap && (hcnt_q == C_H_VINC);

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    vclk_d      = vclk_q;
    vblank_n_d  = vblank_n_q;
    vblankh_n_d = vblankh_n_q;
    ref_dma_n_d = ref_dma_n_q;
    parity_d    = parity_q;
    if (tick) begin
      if (h_wrap) begin
        hcnt_d = C_H_START;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        vclk_d = (hcnt_q >= C_VCLK_FIRST) && (hcnt_q <= C_VCLK_LAST);
      end
    end
    if (v_adv) begin
      if (vcnt_q < C_V_END) begin
        vcnt_d      = vcnt_q + 1'b1;
        vblank_n_d  = (vcnt_q >= C_VACT_FIRST) && (vcnt_q <= C_VACT_LAST);
        vblankh_n_d = !((vcnt_q >= C_VBH_FIRST) && (vcnt_q <= C_VBH_LAST));
        ref_dma_n_d = !((vcnt_q >= C_DMA_FIRST) && (vcnt_q <= C_DMA_LAST));
        if (vcnt_q == C_PARITY_LINE) parity_d = ~parity_q;
      end else begin
        vcnt_d = C_V_START;
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      hcnt_q      <= C_H_START;
      vcnt_q      <= C_V_START;
      vclk_q      <= 1'b0;
      vblank_n_q  <= 1'b0;
      vblankh_n_q <= 1'b0;
      ref_dma_n_q <= 1'b1;
      parity_q    <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      vclk_q      <= vclk_d;
      vblank_n_q  <= vblank_n_d;
      vblankh_n_q <= vblankh_n_d;
      ref_dma_n_q <= ref_dma_n_d;
      parity_q    <= parity_d;
    end
  end

`ifdef VTG_RASTER_IRQ_EN
  logic line_irq_n_q, line_irq_n_d;

  // Ack is honoured on every MCLK edge; a same-edge match overrides it.
  always_comb begin
    line_irq_n_d = line_irq_n_q;
    if (i_IRQ_ACK) line_irq_n_d = 1'b1;
    if (v_adv && (vcnt_d == i_IRQ_LINE)) line_irq_n_d = 1'b0;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) line_irq_n_q <= 1'b1;
    else           line_irq_n_q <= line_irq_n_d;
  end

  assign o_LINE_IRQ_n = line_irq_n_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{i_IRQ_LINE, i_IRQ_ACK};
  assign o_LINE_IRQ_n      = 1'b1;
`endif

  assign o_HCNT        = hcnt_q;
  assign o_VCNT        = vcnt_q;
  assign o_FLIP_H      = hcnt_q[H_WIDTH-2:0] ^ {(H_WIDTH-1){i_HFLIP}};
  assign o_FLIP_V      = vcnt_q[V_WIDTH-2:0] ^ {(V_WIDTH-1){i_VFLIP}};
  assign o_HBLANK_n    = hcnt_q[H_WIDTH-1];
  assign o_VSYNC_n     = vcnt_q[V_WIDTH-1];
  assign o_CSYNC_n     = vcnt_q[V_WIDTH-1] & ~vclk_q;
  assign o_VBLANK_n    = vblank_n_q;
  assign o_VBLANKH_n   = vblankh_n_q;
  assign o_REF_DMA_n   = ref_dma_n_q;
  assign o_VCLK        = vclk_q;
  assign o_FRAMEPARITY = parity_q;

endmodule
`default_nettype wire
